dll_tx_packet_mux: RTL and testbench
====================================

Name: dll_tx_packet_mux

Overview:
- Transmit-side counterpart of the DLL RX packet demux.
- Merges DLLPs from the DLCMSM/ACK-NAK/FC logic and TLPs from the replay/sequence stage into one 1196-bit transmit word stream toward the PHY.
- Arbitrates between the two sources with DLLP priority and a TLP anti-starvation limit.
- Registers the output in a one-entry slot with a valid/ready handshake; gates traffic by DLC state.

Parameters:
- DLLP_BURST_MAX, 4, max consecutive DLLP grants while a TLP is pending before the TLP is forced (1..15).
- CNT_W, 16, width of the transmit statistics counters.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- dlc_state_i  input  2  DLC state: 00 INACTIVE, 01 FEATURE, 10 INIT, 11 ACTIVE
- dllp_i  input  48  DLLP payload
- dllp_valid_i  input  1  DLLP offered
- dllp_ready_o  output  1  DLLP accepted when valid&ready
- tlp_i  input  1196  framed TLP word
- tlp_valid_i  input  1  TLP offered
- tlp_ready_o  output  1  TLP accepted when valid&ready
- tx_data_o  output  1196  transmit word
- tx_valid_o  output  1  transmit word valid
- tx_ready_i  input  1  PHY accepts word
- tlp_fmt_err_o  output  1  one-cycle pulse: TLP offered with bits [1195:48] all zero
- tx_dllp_cnt_o  output  CNT_W  DLLPs sent (wrapping)
- tx_tlp_cnt_o  output  CNT_W  TLPs sent (wrapping)

Behaviour:
- Reset values: all outputs 0; slot empty; burst counter 0.
- Slot free = !tx_valid_o | tx_ready_i.
- Eligibility:
  - DLLP eligible when dllp_valid_i and state is INIT or ACTIVE.
  - TLP eligible when tlp_valid_i, state is ACTIVE, and tlp_i[1195:48] != 0.
- Grant, combinational, only when slot free:
  - Both eligible and burst counter < DLLP_BURST_MAX: DLLP wins.
  - Both eligible and burst counter == DLLP_BURST_MAX: TLP wins.
  - Only one eligible: it wins.
  - dllp_ready_o / tlp_ready_o assert only for the granted source; never both in one cycle.
- Load on grant, next clock edge:
  - DLLP: tx_data_o = {1148'b0, dllp_i}, exactly the encoding the RX demux classifies as DLLP.
  - TLP: tx_data_o = tlp_i.
  - tx_valid_o = 1.
- Latency: 1 cycle from accept to tx_valid_o. Full throughput is one word per cycle while tx_ready_i = 1.
- Hold: tx_data_o and tx_valid_o stay stable while tx_valid_o & !tx_ready_i.
- Burst counter:
  - DLLP grant with TLP eligible: +1, saturating at DLLP_BURST_MAX.
  - TLP grant, or a DLLP grant with no TLP eligible: cleared.
- Statistics counters: tx_dllp_cnt_o / tx_tlp_cnt_o increment on tx_valid_o & tx_ready_i by slot type. Slot type is held in an internal flag. Counters wrap from all-ones to 0.
- Format error:
  - tlp_valid_i with upper bits zero while state is ACTIVE gives tlp_fmt_err_o = 1 for that cycle (registered, visible next cycle).
  - The TLP is never granted and is left for upstream to withdraw.
- State change:
  - dlc_state_i == INACTIVE clears the slot on the next edge (tx_valid_o = 0, word dropped, not counted) and clears the burst counter.
  - Leaving ACTIVE for INIT/FEATURE: a loaded TLP still drains; no new TLP is granted.
- Async reset mid-transfer: slot discarded immediately; no handshake is completed.

Decomposition:
- dll_pkg holds:
  - DLC state localparams (DLC_DL_INACTIVE/FEATURE/INIT/ACTIVE)
  - widths: TX_W = 1196, DLLP_W = 48
  - function is_dllp_word(), shared with the RX demux
- One sub-module, dll_tx_arbiter: eligibility, grant, burst counter.
- Top level holds the output slot, counters and error pulse.

Test Plan:
- ACTIVE, tx_ready_i = 1, DLLP 48'hA5A5_0000_1234 → next cycle tx_data_o = {1148'b0, 48'hA5A5_0000_1234}, tx_valid_o = 1, tx_dllp_cnt_o = 1.
- ACTIVE, DLLP and TLP valid continuously, DLLP_BURST_MAX = 4 → grant pattern D,D,D,D,T repeating; tlp_ready_o high every 5th cycle.
- tx_ready_i = 0 for 3 cycles with TLP loaded → tx_data_o stable, both readys low; on release, TLP counted once.
- State INIT, TLP and DLLP valid → only DLLPs sent, tlp_ready_o stays 0. Switching to ACTIVE → TLP sent.
- TLP with bits [1195:48] = 0 in ACTIVE → tlp_fmt_err_o pulses, no grant; tx_tlp_cnt_o unchanged.
- Slot loaded and stalled, dlc_state_i → INACTIVE → tx_valid_o = 0 next cycle, counters unchanged. Counter preloaded at 16'hFFFF wraps to 0 on the next send.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared DLL definitions: DLC states, word widths and the DLLP/TLP word classifier.
`default_nettype none

package dll_pkg;

  localparam logic [1:0] DLC_DL_INACTIVE = 2'b00;
  localparam logic [1:0] DLC_DL_FEATURE  = 2'b01;
  localparam logic [1:0] DLC_DL_INIT     = 2'b10;
  localparam logic [1:0] DLC_DL_ACTIVE   = 2'b11;

  localparam int TX_W   = 1196;
  localparam int DLLP_W = 48;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'b00,
    SLOT_DLLP  = 2'b01,
    SLOT_TLP   = 2'b10
  } slot_state_e;

  // A word whose bits above the DLLP field are all zero is a DLLP on the wire.
  function automatic logic is_dllp_word(input logic [TX_W-1:0] word);
    return (word[TX_W-1:DLLP_W] == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dll_tx_packet_mux_if.sv
// Handshake bundle between the DLLP/TLP sources, the TX mux and the PHY.
`default_nettype none

interface dll_tx_packet_mux_if;
  import dll_pkg::*;

  logic [DLLP_W-1:0] dllp_i;
  logic              dllp_valid_i;
  logic              dllp_ready_o;
  logic [TX_W-1:0]   tlp_i;
  logic              tlp_valid_i;
  logic              tlp_ready_o;
  logic [TX_W-1:0]   tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;

  modport master (
    output dllp_i, dllp_valid_i, tlp_i, tlp_valid_i, tx_ready_i,
    input  dllp_ready_o, tlp_ready_o, tx_data_o, tx_valid_o
  );

  modport slave (
    input  dllp_i, dllp_valid_i, tlp_i, tlp_valid_i, tx_ready_i,
    output dllp_ready_o, tlp_ready_o, tx_data_o, tx_valid_o
  );

endinterface

`default_nettype wire

// File: rtl/dll_tx_packet_mux_arbiter.sv
// DLLP-priority arbiter with a burst limit that forces a pending TLP through.
`default_nettype none

module dll_tx_arbiter
  import dll_pkg::*;
#(
  parameter int DLLP_BURST_MAX = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] dlc_state,
  input  wire logic       dllp_valid,
  input  wire logic       tlp_valid,
  input  wire logic       tlp_is_dllp_word,
  input  wire logic       slot_free,
  output logic            dllp_grant,
  output logic            tlp_grant,
  output logic            tlp_fmt_err
);

  localparam logic [3:0] BURST_MAX = 4'(DLLP_BURST_MAX);

  logic [3:0] burst_cnt;
  logic       state_active;
  logic       dllp_elig;
  logic       tlp_elig;
  logic       burst_hit;

  assign state_active = (dlc_state == DLC_DL_ACTIVE);
  assign dllp_elig    = dllp_valid && ((dlc_state == DLC_DL_INIT) || state_active);
  assign tlp_elig     = tlp_valid && state_active && !tlp_is_dllp_word;
  assign burst_hit    = (burst_cnt >= BURST_MAX);

  assign dllp_grant  = slot_free && dllp_elig && !(tlp_elig && burst_hit);
  assign tlp_grant   = slot_free && tlp_elig && (!dllp_elig || burst_hit);
  // A malformed TLP is flagged but never granted; upstream must withdraw it.
  assign tlp_fmt_err = tlp_valid && state_active && tlp_is_dllp_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= 4'd0;
    end else if (dlc_state == DLC_DL_INACTIVE) begin
      burst_cnt <= 4'd0;
    end else if (tlp_grant) begin
      burst_cnt <= 4'd0;
    end else if (dllp_grant) begin
      if (!tlp_elig) begin
        burst_cnt <= 4'd0;
      end else if (!burst_hit) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dll_tx_packet_mux.sv
// DLL transmit mux: merges DLLPs and TLPs into a registered one-entry output slot.
`default_nettype none

module dll_tx_packet_mux
  import dll_pkg::*;
#(
  parameter int DLLP_BURST_MAX = 4,
  parameter int CNT_W          = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [1:0]       dlc_state_i,
  dll_tx_packet_mux_if.slave    bus,
  output logic                  tlp_fmt_err_o,
  output logic [CNT_W-1:0]      tx_dllp_cnt_o,
  output logic [CNT_W-1:0]      tx_tlp_cnt_o
);

  slot_state_e     slot_q;
  slot_state_e     slot_nxt;
  logic [TX_W-1:0] data_q;
  logic            slot_free;
  logic            dllp_grant;
  logic            tlp_grant;
  logic            fmt_err_comb;
  logic            inactive;
  logic            handoff;

  assign inactive  = (dlc_state_i == DLC_DL_INACTIVE);
  assign slot_free = (slot_q == SLOT_EMPTY) || bus.tx_ready_i;
  assign handoff   = (slot_q != SLOT_EMPTY) && bus.tx_ready_i && !inactive;

  dll_tx_arbiter #(
    .DLLP_BURST_MAX (DLLP_BURST_MAX)
  ) u_arbiter (
    .clk              (clk),
    .rst_n            (rst_n),
    .dlc_state        (dlc_state_i),
    .dllp_valid       (bus.dllp_valid_i),
    .tlp_valid        (bus.tlp_valid_i),
    .tlp_is_dllp_word (is_dllp_word(bus.tlp_i)),
    .slot_free        (slot_free),
    .dllp_grant       (dllp_grant),
    .tlp_grant        (tlp_grant),
    .tlp_fmt_err      (fmt_err_comb)
  );

  assign bus.dllp_ready_o = dllp_grant;
  assign bus.tlp_ready_o  = tlp_grant;
  assign bus.tx_valid_o   = (slot_q != SLOT_EMPTY);
  assign bus.tx_data_o    = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_nxt;
    end
  end

  // Going INACTIVE drops whatever is in the slot, even mid-stall.
  always_comb begin
    slot_nxt = slot_q;
    if (inactive) begin
      slot_nxt = SLOT_EMPTY;
    end else if (dllp_grant) begin
      slot_nxt = SLOT_DLLP;
    end else if (tlp_grant) begin
      slot_nxt = SLOT_TLP;
    end else if (bus.tx_ready_i) begin
      slot_nxt = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (inactive) begin
      data_q <= '0;
    end else if (dllp_grant) begin
      data_q <= {{(TX_W-DLLP_W){1'b0}}, bus.dllp_i};
    end else if (tlp_grant) begin
      data_q <= bus.tlp_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dllp_cnt_o <= '0;
      tx_tlp_cnt_o  <= '0;
      tlp_fmt_err_o <= 1'b0;
    end else begin
      tlp_fmt_err_o <= fmt_err_comb;
      if (handoff && (slot_q == SLOT_DLLP)) begin
        tx_dllp_cnt_o <= tx_dllp_cnt_o + CNT_W'(1);
      end
      if (handoff && (slot_q == SLOT_TLP)) begin
        tx_tlp_cnt_o <= tx_tlp_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dll_tx_packet_mux.sv
// Directed self-checking bench for dll_tx_packet_mux.
`default_nettype none

module tb_dll_tx_packet_mux;
  import dll_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    dlc_state;
  logic          fmt_err;
  logic [CW-1:0] dllp_cnt;
  logic [CW-1:0] tlp_cnt;

  int total = 0;
  int bad   = 0;

  logic [TX_W-1:0] tlp_a;
  logic [TX_W-1:0] tlp_b;
  logic [TX_W-1:0] tlp_bad;
  logic [TX_W-1:0] exp_w;
  logic [DLLP_W-1:0] d1;
  logic [DLLP_W-1:0] d2;

  dll_tx_packet_mux_if bus ();

  dll_tx_packet_mux #(
    .DLLP_BURST_MAX (4),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dlc_state_i   (dlc_state),
    .bus           (bus),
    .tlp_fmt_err_o (fmt_err),
    .tx_dllp_cnt_o (dllp_cnt),
    .tx_tlp_cnt_o  (tlp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TX_W-1:0] obs, input logic [TX_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h..%h expected=%h..%h", tag,
             obs[TX_W-1:TX_W-32], obs[63:0], exp[TX_W-1:TX_W-32], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TX_W-1:0] dword(input logic [DLLP_W-1:0] d);
    return {{(TX_W-DLLP_W){1'b0}}, d};
  endfunction

  initial begin
    d1 = 48'hA5A5_0000_1234;
    d2 = 48'h1111_2222_3333;
    tlp_a = '0;
    tlp_a[TX_W-1:TX_W-32] = 32'hDEAD_BEEF;
    tlp_a[47:0] = 48'h0000_0000_0ABC;
    tlp_b = '0;
    tlp_b[100:69] = 32'hCAFE_F00D;
    tlp_b[31:0] = 32'h0000_5555;
    tlp_bad = '0;
    tlp_bad[47:0] = 48'h0000_0000_1234;

    rst_n = 1'b0;
    dlc_state = DLC_DL_INACTIVE;
    bus.dllp_i = '0;
    bus.dllp_valid_i = 1'b0;
    bus.tlp_i = '0;
    bus.tlp_valid_i = 1'b0;
    bus.tx_ready_i = 1'b0;
    tick();
    tick();
    check("rst_valid", TX_W'(bus.tx_valid_o), TX_W'(0));
    check("rst_data", bus.tx_data_o, '0);
    check("rst_dcnt", TX_W'(dllp_cnt), TX_W'(0));
    check("rst_tcnt", TX_W'(tlp_cnt), TX_W'(0));
    check("rst_err", TX_W'(fmt_err), TX_W'(0));
    rst_n = 1'b1;
    tick();

    // single DLLP in ACTIVE
    dlc_state = DLC_DL_ACTIVE;
    bus.tx_ready_i = 1'b1;
    bus.dllp_i = d1;
    bus.dllp_valid_i = 1'b1;
    #1;
    check("d1_ready", TX_W'(bus.dllp_ready_o), TX_W'(1));
    check("d1_tready", TX_W'(bus.tlp_ready_o), TX_W'(0));
    tick();
    bus.dllp_valid_i = 1'b0;
    check("d1_valid", TX_W'(bus.tx_valid_o), TX_W'(1));
    check("d1_data", bus.tx_data_o, dword(d1));
    tick();
    check("d1_cnt", TX_W'(dllp_cnt), TX_W'(1));
    check("d1_empty", TX_W'(bus.tx_valid_o), TX_W'(0));

    // burst pattern D,D,D,D,T repeating
    bus.dllp_i = d2;
    bus.tlp_i = tlp_a;
    bus.dllp_valid_i = 1'b1;
    bus.tlp_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("burst_tready_%0d", i), TX_W'(bus.tlp_ready_o), TX_W'((i % 5) == 4));
      check($sformatf("burst_dready_%0d", i), TX_W'(bus.dllp_ready_o), TX_W'((i % 5) != 4));
      tick();
      exp_w = ((i % 5) == 4) ? tlp_a : dword(d2);
      check($sformatf("burst_data_%0d", i), bus.tx_data_o, exp_w);
    end
    bus.dllp_valid_i = 1'b0;
    bus.tlp_valid_i = 1'b0;
    tick();
    check("burst_dcnt", TX_W'(dllp_cnt), TX_W'(9));
    check("burst_tcnt", TX_W'(tlp_cnt), TX_W'(2));

    // stall with TLP loaded
    bus.tlp_i = tlp_b;
    bus.tlp_valid_i = 1'b1;
    bus.tx_ready_i = 1'b0;
    #1;
    check("stall_load_ready", TX_W'(bus.tlp_ready_o), TX_W'(1));
    tick();
    bus.dllp_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_dready_%0d", i), TX_W'(bus.dllp_ready_o), TX_W'(0));
      check($sformatf("stall_tready_%0d", i), TX_W'(bus.tlp_ready_o), TX_W'(0));
      check($sformatf("stall_data_%0d", i), bus.tx_data_o, tlp_b);
      check($sformatf("stall_valid_%0d", i), TX_W'(bus.tx_valid_o), TX_W'(1));
      tick();
    end
    bus.dllp_valid_i = 1'b0;
    bus.tlp_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    tick();
    check("stall_tcnt", TX_W'(tlp_cnt), TX_W'(3));
    check("stall_dcnt", TX_W'(dllp_cnt), TX_W'(9));

    // INIT: DLLPs only, then ACTIVE lets the TLP through
    dlc_state = DLC_DL_INIT;
    bus.dllp_valid_i = 1'b1;
    bus.tlp_valid_i = 1'b1;
    bus.tlp_i = tlp_a;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("init_tready_%0d", i), TX_W'(bus.tlp_ready_o), TX_W'(0));
      check($sformatf("init_dready_%0d", i), TX_W'(bus.dllp_ready_o), TX_W'(1));
      tick();
    end
    dlc_state = DLC_DL_ACTIVE;
    bus.dllp_valid_i = 1'b0;
    #1;
    check("act_tready", TX_W'(bus.tlp_ready_o), TX_W'(1));
    tick();
    bus.tlp_valid_i = 1'b0;
    check("act_data", bus.tx_data_o, tlp_a);
    tick();
    check("init_dcnt", TX_W'(dllp_cnt), TX_W'(12));
    check("init_tcnt", TX_W'(tlp_cnt), TX_W'(4));

    // malformed TLP
    bus.tlp_i = tlp_bad;
    bus.tlp_valid_i = 1'b1;
    #1;
    check("fmt_tready", TX_W'(bus.tlp_ready_o), TX_W'(0));
    check("fmt_err_pre", TX_W'(fmt_err), TX_W'(0));
    tick();
    bus.tlp_valid_i = 1'b0;
    check("fmt_err_pulse", TX_W'(fmt_err), TX_W'(1));
    check("fmt_no_load", TX_W'(bus.tx_valid_o), TX_W'(0));
    tick();
    check("fmt_err_clear", TX_W'(fmt_err), TX_W'(0));
    check("fmt_tcnt", TX_W'(tlp_cnt), TX_W'(4));

    // INACTIVE drops a stalled slot
    bus.tx_ready_i = 1'b0;
    bus.dllp_i = d1;
    bus.dllp_valid_i = 1'b1;
    tick();
    bus.dllp_valid_i = 1'b0;
    check("drop_loaded", TX_W'(bus.tx_valid_o), TX_W'(1));
    dlc_state = DLC_DL_INACTIVE;
    tick();
    check("drop_valid", TX_W'(bus.tx_valid_o), TX_W'(0));
    bus.tx_ready_i = 1'b1;
    tick();
    check("drop_dcnt", TX_W'(dllp_cnt), TX_W'(12));
    check("drop_tcnt", TX_W'(tlp_cnt), TX_W'(4));

    // counter wrap (8-bit counters in this bench)
    dlc_state = DLC_DL_ACTIVE;
    bus.dllp_i = d2;
    bus.dllp_valid_i = 1'b1;
    for (int i = 0; i < 243; i++) tick();
    bus.dllp_valid_i = 1'b0;
    tick();
    check("wrap_full", TX_W'(dllp_cnt), TX_W'(8'hFF));
    bus.dllp_valid_i = 1'b1;
    tick();
    bus.dllp_valid_i = 1'b0;
    tick();
    check("wrap_zero", TX_W'(dllp_cnt), TX_W'(0));

    // async reset mid-transfer
    bus.tx_ready_i = 1'b0;
    bus.dllp_valid_i = 1'b1;
    tick();
    bus.dllp_valid_i = 1'b0;
    check("arst_loaded", TX_W'(bus.tx_valid_o), TX_W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", TX_W'(bus.tx_valid_o), TX_W'(0));
    check("arst_data", bus.tx_data_o, '0);
    check("arst_tcnt", TX_W'(tlp_cnt), TX_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
